// File: rtl/helios_result_collector.sv
// helios_result_collector: splits Helios result frames into header, forwarded body/terminator and latency statistics.
// Optional HELIOS_RESULT_STATS_EN implements max_cycles/cycle_sum; otherwise both read 0.
module helios_result_collector #(
    parameter int MAX_WORDS_PER_TEST = 1024,
    parameter int TEST_COUNT_WIDTH   = 32,
    parameter int CYCLE_SUM_WIDTH    = 48,
    parameter int WC_WIDTH           = $clog2(MAX_WORDS_PER_TEST + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [31:0]                 out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    input  logic                        clear_stats,
    output logic                        test_done,
    output logic [15:0]                 last_cycles,
    output logic [7:0]                  last_iterations,
    output logic [WC_WIDTH-1:0]         last_word_count,
    output logic [TEST_COUNT_WIDTH-1:0] test_count,
    output logic [15:0]                 max_cycles,
    output logic [CYCLE_SUM_WIDTH-1:0]  cycle_sum,
    output logic                        overflow_err,
    output logic                        protocol_err
);
    typedef enum logic {HEADER, BODY} state_t;

    localparam logic [31:0]         TERM   = 32'hffffffff;
    localparam logic [WC_WIDTH-1:0] WC_MAX = WC_WIDTH'(MAX_WORDS_PER_TEST);

    state_t              state, state_next;
    logic                accept, is_term, hdr_load, hdr_term, body_word, fwd_word, drop_word, commit;
    logic [15:0]         header_cycles;
    logic [7:0]          header_iters;
    logic [WC_WIDTH-1:0] word_count;

    always_comb begin
        in_ready   = (state == HEADER) ? 1'b1 : (!out_valid || out_ready);
        accept     = in_valid && in_ready;
        is_term    = in_data == TERM;
        hdr_load   = accept && state == HEADER && !is_term;
        hdr_term   = accept && state == HEADER && is_term;
        body_word  = accept && state == BODY && !is_term;
        fwd_word   = body_word && word_count < WC_MAX;
        drop_word  = body_word && !fwd_word;
        commit     = accept && state == BODY && is_term;
        state_next = hdr_load ? BODY : commit ? HEADER : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= HEADER;
            out_data        <= '0;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            header_cycles   <= '0;
            header_iters    <= '0;
            word_count      <= '0;
            test_done       <= 1'b0;
            last_cycles     <= '0;
            last_iterations <= '0;
            last_word_count <= '0;
            test_count      <= '0;
            overflow_err    <= 1'b0;
            protocol_err    <= 1'b0;
        end else begin
            state     <= state_next;
            test_done <= commit;
            if (fwd_word || commit) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
                out_last  <= commit;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (hdr_load) begin
                header_cycles <= in_data[15:0];
                header_iters  <= in_data[23:16];
                word_count    <= '0;
            end else if (fwd_word) begin
                word_count <= word_count + WC_WIDTH'(1);
            end
            if (commit) begin
                last_cycles     <= header_cycles;
                last_iterations <= header_iters;
                last_word_count <= word_count;
            end
            // clear outranks a coincident commit or error for the aggregates
            if (clear_stats) begin
                test_count   <= '0;
                overflow_err <= 1'b0;
                protocol_err <= 1'b0;
            end else begin
                if (commit) test_count <= test_count + TEST_COUNT_WIDTH'(1);
                if (drop_word) overflow_err <= 1'b1;
                if (hdr_term) protocol_err <= 1'b1;
            end
        end
    end

`ifdef HELIOS_RESULT_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_cycles <= '0;
            cycle_sum  <= '0;
        end else if (clear_stats) begin
            max_cycles <= '0;
            cycle_sum  <= '0;
        end else if (commit) begin
            max_cycles <= (header_cycles > max_cycles) ? header_cycles : max_cycles;
            cycle_sum  <= cycle_sum + CYCLE_SUM_WIDTH'(header_cycles);
        end
    end
`else
    assign max_cycles = '0;
    assign cycle_sum  = '0;
`endif
endmodule

// File: tb/tb_helios_result_collector.sv
// tb_helios_result_collector: random frames against a frame-level reference model of the collector.
module tb_helios_result_collector;
    localparam int MAXW = 4;
    localparam int WCW  = $clog2(MAXW + 1);
    localparam logic [31:0] TERM = 32'hffffffff;

    logic clk, reset, in_valid, in_ready, out_valid, out_ready, out_last, clear_stats, test_done;
    logic overflow_err, protocol_err;
    logic [31:0] in_data, out_data, test_count;
    logic [15:0] last_cycles, max_cycles;
    logic [7:0]  last_iterations;
    logic [WCW-1:0] last_word_count;
    logic [47:0] cycle_sum;

    helios_result_collector #(.MAX_WORDS_PER_TEST(MAXW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .clear_stats(clear_stats), .test_done(test_done), .last_cycles(last_cycles),
        .last_iterations(last_iterations), .last_word_count(last_word_count), .test_count(test_count),
        .max_cycles(max_cycles), .cycle_sum(cycle_sum), .overflow_err(overflow_err),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks, n_err, mode, done_pulses;
    bit in_body, prev_stall;
    logic [32:0] prev_out;
    logic [32:0] exp_q[$], got_q[$];
    int unsigned m_count;
    logic [15:0] m_max, m_lcyc;
    logic [7:0]  m_lit;
    int          m_lwc;
    logic [47:0] m_sum;
    bit          m_ovf, m_perr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_max = '0; m_sum = '0; m_lcyc = '0; m_lit = '0; m_lwc = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic check_stats();
        check("last_cycles", last_cycles, m_lcyc);
        check("last_iterations", last_iterations, m_lit);
        check("last_word_count", last_word_count, 64'(m_lwc));
        check("test_count", test_count, m_count);
        check("overflow_err", overflow_err, m_ovf);
        check("protocol_err", protocol_err, m_perr);
`ifdef HELIOS_RESULT_STATS_EN
        check("max_cycles", max_cycles, m_max);
        check("cycle_sum", cycle_sum, m_sum);
`else
        check("max_cycles", max_cycles, 0);
        check("cycle_sum", cycle_sum, 0);
`endif
    endtask

    // called at a negedge; drives out_ready, samples mid-cycle, returns at the next negedge
    task automatic tick(output bit acc);
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !out_ready : 1'($urandom % 2);
        #1;
        acc = in_valid && in_ready;
        if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_hold", {out_last, out_data}, prev_out);
        end
        if (in_body && out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) got_q.push_back({out_last, out_data});
        if (test_done) begin
            done_pulses++;
            check("done_test_count", test_count, m_count);
        end
        prev_stall = out_valid && !out_ready;
        prev_out = {out_last, out_data};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] w);
        bit acc;
        int guard;
        if ($urandom % 4 == 0) tick(acc);
        in_data = w;
        in_valid = 1'b1;
        guard = 0;
        do begin
            tick(acc);
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check("send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [15:0] cyc, input logic [7:0] it, input int n);
        logic [31:0] w;
        bit d;
        int guard;
        exp_q.delete();
        got_q.delete();
        done_pulses = 0;
        send({8'h00, it, cyc});
        in_body = 1;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (w == TERM) w = 32'h0;
            send(w);
            if (i < MAXW) exp_q.push_back({1'b0, w});
        end
        send(TERM);
        exp_q.push_back({1'b1, TERM});
        in_body = 0;
        m_lcyc = cyc; m_lit = it; m_lwc = (n < MAXW) ? n : MAXW; m_count++;
        if (cyc > m_max) m_max = cyc;
        m_sum += 48'(cyc);
        if (n > MAXW) m_ovf = 1;
        guard = 0;
        do begin
            tick(d);
            guard++;
        end while (got_q.size() < exp_q.size() && guard < 100);
        check("frame_len", got_q.size(), exp_q.size());
        foreach (exp_q[i]) if (i < got_q.size()) check("frame_word", got_q[i], exp_q[i]);
        check("done_pulses", done_pulses, 1);
        check_stats();
    endtask

    initial begin
        bit d;
        reset = 0; in_valid = 0; in_data = '0; out_ready = 1; clear_stats = 0; mode = 0;
        in_body = 0; prev_stall = 0; prev_out = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_test_done", test_done, 0);
        check_stats();
        reset = 1;
        @(negedge clk);

        mode = 0; frame(16'h0040, 8'h03, 2);
        mode = 1; frame(16'h0040, 8'h03, 2);

        mode = 2;
        frame(16'd100, 8'd1, 3);
        frame(16'd250, 8'd2, 1);
        frame(16'd80, 8'd7, 4);
        clear_stats = 1;
        tick(d);
        clear_stats = 0;
        m_count = 0; m_max = '0; m_sum = '0; m_ovf = 0; m_perr = 0;
        check_stats();

        frame(16'h1234, 8'h05, 6);

        got_q.delete();
        done_pulses = 0;
        send(TERM);
        m_perr = 1;
        tick(d);
        tick(d);
        check("perr_no_output", got_q.size(), 0);
        check("perr_no_done", done_pulses, 0);
        check_stats();
        frame(16'h0777, 8'h11, 3);

        for (int k = 0; k < 10; k++) begin
            mode = $urandom_range(0, 2);
            frame(16'($urandom), 8'($urandom), $urandom_range(0, 6));
        end

        mode = 0;
        got_q.delete();
        send({8'h00, 8'h09, 16'h0999});
        in_body = 1;
        send(32'h0badf00d);
        reset = 0;
        #1;
        model_reset();
        in_body = 0;
        prev_stall = 0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_last", out_last, 0);
        check_stats();
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        frame(16'h0040, 8'h03, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/helios_result_collector.md
# helios_result_collector

Downstream consumer of the Helios decoder's 32-bit result stream on a leaf FPGA. Sits after the output FIFO and splits each result frame into its header, correction words and terminator. The header is the first word: cycle count in bits [15:0], iteration count in bits [23:16]. The terminator is 32'hffffffff. Correction words and the terminator are forwarded to a sink, and per-test and aggregate latency statistics are kept for host readout.

## Interface
Parameters:
- MAX_WORDS_PER_TEST, 1024: maximum correction words forwarded per frame.
- TEST_COUNT_WIDTH, 32: width of the test counter.
- CYCLE_SUM_WIDTH, 48: width of the cycle accumulator.
- WC_WIDTH, $clog2(MAX_WORDS_PER_TEST+1): derived width of the word counter.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  32  decoder result word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  collector accepts in_data.
- out_data  output  32  forwarded correction word or terminator.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts out_data.
- out_last  output  1  out_data is the terminator.
- clear_stats  input  1  synchronous clear of aggregate statistics.
- test_done  output  1  one-cycle pulse per completed frame.
- last_cycles  output  16  header cycle count of the last completed frame.
- last_iterations  output  8  header iteration count of the last completed frame.
- last_word_count  output  WC_WIDTH  correction words seen in the last frame, saturating.
- test_count  output  TEST_COUNT_WIDTH  completed frames.
- max_cycles  output  16  largest last_cycles since clear.
- cycle_sum  output  CYCLE_SUM_WIDTH  sum of last_cycles since clear.
- overflow_err  output  1  sticky: a frame exceeded MAX_WORDS_PER_TEST.
- protocol_err  output  1  sticky: terminator received in the HEADER state.

## Operation
- FSM states: HEADER (reset state) and BODY.
- HEADER:
  - in_ready = 1.
  - A non-terminator word is captured into the header_cycles/header_iters shadow registers. Word count clears; FSM moves to BODY. The header is not forwarded.
  - A terminator word is consumed and dropped. protocol_err is set; FSM stays in HEADER.
- BODY:
  - in_ready = !out_valid || out_ready. The output is a single register stage.
  - Non-terminator word: loaded into out_data with out_last=0 if the word count is below MAX_WORDS_PER_TEST, and the count increments. Otherwise the word is consumed and dropped, overflow_err is set, and the count holds at MAX_WORDS_PER_TEST.
  - Terminator word: loaded with out_last=1 (always forwarded). The commit happens on the same edge. FSM moves to HEADER.
- Commit, on the terminator handshake edge:
  - last_cycles, last_iterations and last_word_count take the shadow values.
  - test_count increments, wrapping at 2^TEST_COUNT_WIDTH.
  - max_cycles = max(max_cycles, header_cycles).
  - cycle_sum += header_cycles, zero-extended, wrapping.
  - test_done = 1 for the following cycle.
- clear_stats zeroes test_count, max_cycles, cycle_sum, overflow_err and protocol_err. If it coincides with a commit, the clear wins for aggregates; the last_* registers still update.
- Reset value of every output is 0, except in_ready, which is 1 (FSM in HEADER). An empty out register is dropped. Reset mid-frame discards the partial frame.

## Timing
- Input to out_valid latency: 1 cycle. Word accepted at edge N is presented on out_data from N+1.
- Full throughput of 1 word/cycle in BODY while out_ready=1. When out_ready=0 and out_valid=1, in_ready=0 combinationally.
- out_data, out_valid and out_last are held stable while out_valid && !out_ready.
- Header consumption costs 1 cycle with no output.
- Statistics are visible the cycle test_done is high.

## Configuration
- HELIOS_RESULT_STATS_EN:
  - Defined: max_cycles and cycle_sum are implemented as described.
  - Undefined: both are tied to 0 with no registers.
  - Either way: test_count, the last_* outputs and the error flags remain.

## Test plan
- Frame 0x00030040, A, B, 0xffffffff with out_ready=1:
  - out emits A, B, then 0xffffffff with out_last=1 on the third output.
  - test_done pulses.
  - last_cycles=0x40, last_iterations=3, last_word_count=2, test_count=1.
- Same frame with out_ready toggling 1/0:
  - No word is lost or duplicated; out_data is stable while stalled; in_ready=0 during the stall.
- Three frames with cycles 100, 250, 80:
  - max_cycles=250, cycle_sum=430, test_count=3.
  - Then clear_stats: all three read 0, and last_cycles stays 80.
- MAX_WORDS_PER_TEST=4, frame carrying 6 words:
  - Only the first 4 words plus the terminator are forwarded.
  - last_word_count=4, overflow_err=1.
- 0xffffffff received in HEADER: dropped, protocol_err=1, next frame parses normally.
- Assert reset low after the header and one word: outputs read 0, FSM is in HEADER, and a new frame decodes correctly.
